mod_inverse_ctrl: RTL and testbench

//  Computes RSA private exponent d = e^-1 mod phi. Sits downstream of key setup and wraps the extended binary GCD engine.

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/mod_reduce_step.sv | 38 +++
 rtl/mod_inverse_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mod_inverse_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types for the RSA private-exponent sequencer: the
//                controller state encoding and the result status codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

    // Controller states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARG_CHK = 3'd1,
        GCD_RST = 3'd2,
        GCD_RUN = 3'd3,
        CHECK   = 3'd4,
        NORM    = 3'd5,
        DONE    = 3'd6
    } modinv_state_t;

    // Result codes presented alongside d_out.
    typedef enum logic [1:0] {
        OK          = 2'd0,
        NOT_COPRIME = 2'd1,
        BAD_ARG     = 2'd2,
        TIMEOUT     = 2'd3
    } modinv_status_t;

endpackage : rsa_pkg

`default_nettype wire

// File: rtl/mod_reduce_step.sv
// ============================================================================
//  Module      : mod_reduce_step
//  Description : One combinational normalisation step on a (WORD_WIDTH+1)-bit
//                signed accumulator: adds the modulus when negative, subtracts
//                it when >= modulus, otherwise flags the value as in range.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_reduce_step #(
    parameter int WORD_WIDTH = 32
) (
    input  logic signed [WORD_WIDTH:0]   i_acc,
    input  logic        [WORD_WIDTH-1:0] i_mod,
    output logic signed [WORD_WIDTH:0]   o_acc_next,
    output logic                         o_in_range
);

    // Modulus widened with a zero sign bit so it compares as a positive value.
    logic signed [WORD_WIDTH:0] w_mod_ext;
    assign w_mod_ext = $signed({1'b0, i_mod});

    // Pick one correction step; the extra bit keeps every result exact.
    always_comb begin
        o_acc_next = i_acc;
        o_in_range = 1'b0;
        if (i_acc < 0) begin
            o_acc_next = i_acc + w_mod_ext;
        end else if (i_acc >= w_mod_ext) begin
            o_acc_next = i_acc - w_mod_ext;
        end else begin
            o_in_range = 1'b1;
        end
    end

endmodule : mod_reduce_step

`default_nettype wire

// File: rtl/mod_inverse_ctrl.sv
// ============================================================================
//  Module      : mod_inverse_ctrl
//  Description : Computes d = e^-1 mod phi by sequencing an external extended
//                binary GCD engine, checking gcd == 1 and folding the Bezout
//                coefficient into [0, phi). Result leaves on valid/ready.
//                Optional watchdog enabled by defining MODINV_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_inverse_ctrl
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] e_in,
    input  logic [WORD_WIDTH-1:0] phi_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] d_out,
    output logic [1:0]            status,
    output logic                  gcd_reset,
    output logic                  gcd_enable,
    output logic [WORD_WIDTH-1:0] gcd_x,
    output logic [WORD_WIDTH-1:0] gcd_y,
    input  logic                  gcd_done,
    input  logic [WORD_WIDTH-1:0] gcd_result,
    input  logic [WORD_WIDTH-1:0] gcd_coeff_i
);

    // A watchdog limit below 2 leaves no room for even one engine cycle.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("mod_inverse_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    modinv_state_t              r_state;
    modinv_status_t             r_status;
    logic [WORD_WIDTH-1:0]      r_e;
    logic [WORD_WIDTH-1:0]      r_phi;
    logic [WORD_WIDTH-1:0]      r_d;
    logic signed [WORD_WIDTH:0] r_acc;
    logic                       r_busy;
    logic                       r_out_valid;
    logic                       r_gcd_enable;

    logic signed [WORD_WIDTH:0] w_acc_next;
    logic                       w_in_range;

    mod_reduce_step #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_reduce (
        .i_acc      (r_acc),
        .i_mod      (r_phi),
        .o_acc_next (w_acc_next),
        .o_in_range (w_in_range)
    );

`ifdef MODINV_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              w_timeout;

    assign w_timeout = ((r_state == GCD_RUN) || (r_state == NORM)) && (r_wdog == c_WD_LAST);

    // Watchdog: zeroed in GCD_RST so it starts at 0 on the first GCD_RUN cycle,
    // then advances only while waiting on the engine or normalising.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (r_state == GCD_RST) begin
            r_wdog <= '0;
        end else if ((r_state == GCD_RUN) || (r_state == NORM)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`endif

    // Engine reset follows the system reset and is also pulsed for the single
    // GCD_RST cycle so a stale done from a previous run can never be seen.
    assign gcd_reset  = reset & (r_state != GCD_RST);
    assign gcd_enable = r_gcd_enable;
    assign gcd_x      = r_e;
    assign gcd_y      = r_phi;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign d_out      = r_d;
    assign status     = r_status;

    // Main sequencer: capture, argument check, engine run, coprime check,
    // normalisation and result hand-off, all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_status     <= OK;
            r_e          <= '0;
            r_phi        <= '0;
            r_d          <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_gcd_enable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_e     <= e_in;
                        r_phi   <= phi_in;
                        r_busy  <= 1'b1;
                        r_state <= ARG_CHK;
                    end
                end
                ARG_CHK: begin
                    // Zero operands would hang the engine, so reject them here.
                    if ((r_e == '0) || (r_phi < WORD_WIDTH'(2)) || (r_e >= r_phi)) begin
                        r_status    <= BAD_ARG;
                        r_d         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= GCD_RST;
                    end
                end
                GCD_RST: begin
                    r_gcd_enable <= 1'b1;
                    r_state      <= GCD_RUN;
                end
                GCD_RUN: begin
`ifdef MODINV_TIMEOUT_EN
                    if (w_timeout) begin
                        r_gcd_enable <= 1'b0;
                        r_status     <= TIMEOUT;
                        r_d          <= '0;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end else
`endif
                    if (gcd_done) begin
                        r_gcd_enable <= 1'b0;
                        r_state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (gcd_result != WORD_WIDTH'(1)) begin
                        r_status    <= NOT_COPRIME;
                        r_d         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_acc   <= {gcd_coeff_i[WORD_WIDTH-1], gcd_coeff_i};
                        r_state <= NORM;
                    end
                end
                NORM: begin
`ifdef MODINV_TIMEOUT_EN
                    if (w_timeout) begin
                        r_status    <= TIMEOUT;
                        r_d         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else
`endif
                    if (w_in_range) begin
                        r_d         <= r_acc[WORD_WIDTH-1:0];
                        r_status    <= OK;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end
                DONE: begin
                    // A start in the accept cycle is dropped: we are not in IDLE yet.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mod_inverse_ctrl

`default_nettype wire

// File: tb/tb_mod_inverse_ctrl.sv
// ============================================================================
//  Module      : tb_mod_inverse_ctrl
//  Description : Self-checking bench for mod_inverse_ctrl with a behavioural
//                extended-GCD engine and a scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_inverse_ctrl;

    localparam int W       = 32;
    localparam int ENG_LAT = 6;
`ifdef MODINV_TIMEOUT_EN
    localparam int TO_CYC  = 4;
`else
    localparam int TO_CYC  = 4096;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] e_in = '0;
    logic [W-1:0] phi_in = '0;
    logic         out_ready = 1'b0;
    logic         busy, out_valid, gcd_reset, gcd_enable;
    logic [W-1:0] d_out, gcd_x, gcd_y;
    logic [1:0]   status;
    logic         gcd_done;
    logic [W-1:0] gcd_result, gcd_coeff_i;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   st;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   eng_bias = 0;
    bit   en_seen = 1'b0;
    int   eng_cnt;

    always #5 clk = ~clk;

    mod_inverse_ctrl #(
        .WORD_WIDTH     (W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .e_in        (e_in),
        .phi_in      (phi_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .d_out       (d_out),
        .status      (status),
        .gcd_reset   (gcd_reset),
        .gcd_enable  (gcd_enable),
        .gcd_x       (gcd_x),
        .gcd_y       (gcd_y),
        .gcd_done    (gcd_done),
        .gcd_result  (gcd_result),
        .gcd_coeff_i (gcd_coeff_i)
    );

    // Iterative extended Euclid: g = gcd(a,b), s*a + t*b = g.
    function automatic void ext_gcd(input longint a, input longint b,
                                    output longint g, output longint s);
        longint old_r = a, r = b, old_s = 1, s_cur = 0, q, tmp;
        while (r != 0) begin
            q = old_r / r;
            tmp = r;     r = old_r - q * r;         old_r = tmp;
            tmp = s_cur; s_cur = old_s - q * s_cur; old_s = tmp;
        end
        g = old_r;
        s = old_s;
    endfunction

    // Behavioural engine: ENG_LAT enabled cycles, then done held until reset.
    // eng_bias shifts the coefficient by a multiple of y (still a valid Bezout value).
    always @(posedge clk or negedge gcd_reset) begin
        longint g, s;
        if (!gcd_reset) begin
            eng_cnt     <= 0;
            gcd_done    <= 1'b0;
            gcd_result  <= '0;
            gcd_coeff_i <= '0;
        end else if (gcd_enable && !gcd_done) begin
            if (eng_cnt == ENG_LAT - 1) begin
                ext_gcd(longint'(gcd_x), longint'(gcd_y), g, s);
                gcd_result  <= W'(g);
                gcd_coeff_i <= W'(s + longint'(eng_bias) * longint'(gcd_y));
                gcd_done    <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    always @(negedge clk) if (gcd_enable) en_seen = 1'b1;

    // Push the expected result, issue one request, wait (bounded) for out_valid.
    task automatic run_op(input logic [W-1:0] e, input logic [W-1:0] phi, input int bias,
                          output int lat);
        exp_t   x;
        longint g, s, ph;
        ph = longint'(phi);
        if (e == 0 || phi < 2 || e >= phi) begin
            x.d = '0; x.st = 2'd2;
        end else begin
            ext_gcd(longint'(e), ph, g, s);
            if (g != 1) begin
                x.d = '0; x.st = 2'd1;
            end else begin
                x.d = W'(((s % ph) + ph) % ph); x.st = 2'd0;
            end
`ifdef MODINV_TIMEOUT_EN
            x.d = '0; x.st = 2'd3;
`endif
        end
        sb_q.push_back(x);
        eng_bias = bias;
        e_in = e; phi_in = phi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL wait_valid e=%0d phi=%0d: out_valid never rose within %0d cycles", e, phi, lat);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (gcd_reset !== 1'b0)  begin n_fail++; $display("FAIL rst_gcd_reset got %b want 0", gcd_reset); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_tests++; if (gcd_enable !== 1'b0) begin n_fail++; $display("FAIL rst_gcd_enable got %b want 0", gcd_enable); end
        n_tests++; if (d_out !== '0)        begin n_fail++; $display("FAIL rst_d_out got %0d want 0", d_out); end
        n_tests++; if (status !== 2'd0)     begin n_fail++; $display("FAIL rst_status got %0d want 0", status); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (gcd_reset !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_release gcd_reset=%b busy=%b want 1/0", gcd_reset, busy);
        end
    endtask

    task automatic test_inverse(input logic [W-1:0] e, input logic [W-1:0] phi, input int bias);
        int   lat;
        exp_t x;
        run_op(e, phi, bias, lat);
        x = sb_q.pop_front();
        n_tests++; if (d_out !== x.d || status !== x.st) begin
            n_fail++; $display("FAIL inverse e=%0d phi=%0d bias=%0d got d=%0d st=%0d want d=%0d st=%0d",
                               e, phi, bias, d_out, status, x.d, x.st);
        end
        if (x.st == 2'd0) begin
            n_tests++; if ((longint'(e) * longint'(d_out)) % longint'(phi) != 1) begin
                n_fail++; $display("FAIL inverse_prod e=%0d phi=%0d d=%0d got (e*d)%%phi=%0d want 1",
                                   e, phi, d_out, (longint'(e) * longint'(d_out)) % longint'(phi));
            end
        end
        accept();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL inverse_accept got valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_bad_arg(input logic [W-1:0] e, input logic [W-1:0] phi);
        int   lat;
        exp_t x;
        en_seen = 1'b0;
        run_op(e, phi, 0, lat);
        x = sb_q.pop_front();
        n_tests++; if (d_out !== x.d || status !== x.st) begin
            n_fail++; $display("FAIL bad_arg e=%0d phi=%0d got d=%0d st=%0d want d=%0d st=%0d",
                               e, phi, d_out, status, x.d, x.st);
        end
        n_tests++; if (lat != 2) begin
            n_fail++; $display("FAIL bad_arg_latency e=%0d phi=%0d got %0d want 2", e, phi, lat);
        end
        accept();
        n_tests++; if (en_seen) begin
            n_fail++; $display("FAIL bad_arg_enable e=%0d phi=%0d got gcd_enable=1 want never", e, phi);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t x;
        run_op(32'd3, 32'd20, 1, lat);
        x = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0); e_in = 32'd5; phi_in = 32'd7;
            @(posedge clk); #1;
            n_tests++; if (out_valid !== 1'b1 || d_out !== x.d || status !== x.st) begin
                n_fail++; $display("FAIL hold cyc=%0d got v=%b d=%0d st=%0d want v=1 d=%0d st=%0d",
                                   i, out_valid, d_out, status, x.d, x.st);
            end
        end
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_accept got v=%b busy=%b want 0/0", out_valid, busy);
        end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin
            n_fail++; $display("FAIL start_in_accept got busy=%b want 0", busy);
        end
        test_inverse(32'd17, 32'd3120, 1);
    endtask

    task automatic test_reset_mid();
        int wait_cyc = 0;
        eng_bias = 0;
        e_in = 32'd17; phi_in = 32'd3120; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!gcd_enable && wait_cyc < 20) begin @(posedge clk); #1; wait_cyc++; end
        n_tests++; if (gcd_enable !== 1'b1) begin
            n_fail++; $display("FAIL mid_enable got %b want 1", gcd_enable);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_tests++; if ({busy, out_valid, gcd_enable, gcd_reset} !== 4'b0 || d_out !== '0 || status !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset got busy=%b v=%b en=%b grst=%b d=%0d st=%0d want all 0",
                               busy, out_valid, gcd_enable, gcd_reset, d_out, status);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        test_inverse(32'd17, 32'd3120, 0);
    endtask

    task automatic test_timeout();
        int   lat;
        exp_t x;
        run_op(32'd17, 32'd3120, 0, lat);
        x = sb_q.pop_front();
        n_tests++; if (d_out !== x.d || status !== x.st) begin
            n_fail++; $display("FAIL timeout got d=%0d st=%0d want d=%0d st=%0d", d_out, status, x.d, x.st);
        end
        n_tests++; if (gcd_enable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_enable got %b want 0", gcd_enable);
        end
        accept();
    endtask

    initial begin
        test_reset();
`ifdef MODINV_TIMEOUT_EN
        test_timeout();
`else
        test_inverse(32'd17, 32'd3120, 0);
        test_inverse(32'd17, 32'd3120, -1);
        test_inverse(32'd3, 32'd20, 0);
        test_inverse(32'd3, 32'd20, 1);
        test_inverse(32'd6, 32'd20, 0);
        test_bad_arg(32'd0, 32'd20);
        test_bad_arg(32'd25, 32'd20);
        test_bad_arg(32'd1, 32'd1);
        test_backpressure();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mod_inverse_ctrl

`default_nettype wire
